// File: rtl/display_source_scheduler_pkg.sv
// disp_pkg: shared definitions for the display source scheduler.
//   - DISP_DW / DISP_MAXVAL : default data width and largest value the
//     four-digit seven-segment driver can show.
//   - MODE_* : encodings of the 2-bit mode input.
//   - state_e : scheduler states.
package disp_pkg;

  localparam int DISP_DW     = 16;
  localparam int DISP_MAXVAL = 9999;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_EVENT  = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_ROTATE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

endpackage

// File: rtl/display_source_scheduler_rr_pick.sv
// rr_pick: combinational round-robin finder.
//   req   : one request bit per source
//   base  : first index to examine; search wraps NSRC-1 -> 0 and ends at base-1
//   grant : first requesting index found from base onward (base when none)
//   found : at least one request bit is set
module rr_pick #(
  parameter int NSRC = 4,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] base,
  output logic [SELW-1:0] grant,
  output logic            found
);

  // base + off, wrapped into 0..NSRC-1 (both operands are below NSRC)
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] b, input int off);
    int s;
    s = int'(b) + off;
    if (s >= NSRC) s = s - NSRC;
    return SELW'(s);
  endfunction

  // cand[k] is the k-th index examined
  logic [SELW-1:0] cand [NSRC];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_cand
    assign cand[gi] = wrap_idx(base, gi);
  end

  // Scan from the far end so the closest candidate to base wins.
  always_comb begin
    grant = base;
    found = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        grant = cand[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// display_source_scheduler: shares one four-digit seven-segment display
// between NSRC requesters in MANUAL, ROTATE, EVENT or FREEZE mode.
//   clk, rst_n  : clock, synchronous active-low reset
//   src_data    : packed source values, source i at [i*DW +: DW]
//   src_valid   : source i has a meaningful value
//   src_upd     : one-cycle pulse, source i changed and wants the display
//   mode        : 00 MANUAL, 01 ROTATE, 10 EVENT, 11 FREEZE
//   man_sel     : source shown in MANUAL
//   disp_num    : registered value for the driver (saturated to MAXVAL)
//   disp_src    : index currently shown
//   disp_ovf    : shown value was saturated
//   disp_blank  : shown source is invalid, disp_num=0
//   sel_change  : one-cycle pulse when disp_src takes a new value
module display_source_scheduler
  import disp_pkg::*;
#(
  parameter  int NSRC   = 4,
  parameter  int DW     = DISP_DW,
  parameter  int DWELL  = 100_000_000,
  parameter  int HOLD   = 50_000_000,
  parameter  int MAXVAL = DISP_MAXVAL,
  localparam int SELW   = $clog2(NSRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*DW-1:0]   src_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [NSRC-1:0]      src_upd,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      man_sel,
  output logic [DW-1:0]        disp_num,
  output logic [SELW-1:0]      disp_src,
  output logic                 disp_ovf,
  output logic                 disp_blank,
  output logic                 sel_change
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLD - 1);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               frz_evt_q, frz_evt_d;   // FREEZE was entered from EVENT
  logic [SELW-1:0]    cur_sel_q, cur_sel_d;
  logic [DCW-1:0]     dwell_q, dwell_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic [NSRC-1:0]    pending_q, pending_d;
  logic [DW-1:0]      disp_num_q, disp_num_d;
  logic [SELW-1:0]    disp_src_q, disp_src_d;
  logic               disp_ovf_q, disp_ovf_d;
  logic               disp_blank_q, disp_blank_d;
  logic               sel_change_q, sel_change_d;

  logic [DW-1:0]      src_val [NSRC];
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign src_val[gi] = src_data[gi*DW +: DW];
  end

  logic [SELW-1:0]    next_base;
  logic [NSRC-1:0]    cur_oh, req_vec, req_new, evt_req;
  logic               pend_en;
  logic [SELW-1:0]    evt_grant, rot_grant;
  logic               evt_found, rot_found;

  assign next_base = (cur_sel_q == SELW'(NSRC - 1)) ? '0 : cur_sel_q + SELW'(1);
  assign cur_oh    = {{(NSRC-1){1'b0}}, 1'b1} << cur_sel_q;
  assign req_vec   = src_upd & src_valid;
  // During a hold, an update from the shown source only restarts the hold.
  assign req_new   = (state_q == ST_HOLD) ? (req_vec & ~cur_oh) : req_vec;
  assign pend_en   = (mode_q == MODE_EVENT) || ((mode_q == MODE_FREEZE) && frz_evt_q);
  // Requests arriving this cycle join the pick together with older ones.
  assign evt_req   = pend_en ? (pending_q | req_new) : '0;

  rr_pick #(.NSRC(NSRC), .SELW(SELW)) u_pick_rot (
    .req   (src_valid),
    .base  (next_base),
    .grant (rot_grant),
    .found (rot_found)
  );

  rr_pick #(.NSRC(NSRC), .SELW(SELW)) u_pick_evt (
    .req   (evt_req),
    .base  (next_base),
    .grant (evt_grant),
    .found (evt_found)
  );

  // Next-state / scheduling
  always_comb begin
    state_d   = state_q;
    mode_d    = mode;
    frz_evt_d = frz_evt_q;
    cur_sel_d = cur_sel_q;
    dwell_d   = dwell_q;
    hold_d    = hold_q;
    pending_d = evt_req;

    if (mode_q != MODE_FREEZE) frz_evt_d = (mode_q == MODE_EVENT);

    if (mode != mode_q) begin
      dwell_d = '0;
      hold_d  = '0;
      unique case (mode)
        MODE_MANUAL: state_d = ST_MANUAL;
        MODE_FREEZE: state_d = ST_FREEZE;
        default:     state_d = ST_ROTATE;   // ROTATE and EVENT
      endcase
    end else begin
      unique case (state_q)
        ST_MANUAL: begin
          if ({1'b0, man_sel} < (SELW+1)'(NSRC)) cur_sel_d = man_sel;
          pending_d = '0;
        end
        ST_ROTATE: begin
          if (evt_found) begin
            cur_sel_d = evt_grant;
            pending_d = evt_req & ~({{(NSRC-1){1'b0}}, 1'b1} << evt_grant);
            state_d   = ST_HOLD;
            hold_d    = '0;
            dwell_d   = '0;
          end else if (dwell_q == DWELL_LAST) begin
            // With nothing valid the counter parks at its terminal value.
            if (rot_found) begin
              cur_sel_d = rot_grant;
              dwell_d   = '0;
            end
          end else begin
            dwell_d = dwell_q + DCW'(1);
          end
        end
        ST_HOLD: begin
          if (req_vec[cur_sel_q]) begin
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (evt_found) begin
              cur_sel_d = evt_grant;
              pending_d = evt_req & ~({{(NSRC-1){1'b0}}, 1'b1} << evt_grant);
            end else begin
              state_d = ST_ROTATE;
              dwell_d = '0;
            end
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
        default: ;   // ST_FREEZE: everything held, pending still latches
      endcase
    end
  end

  // Output stage: one cycle behind cur_sel / src_data, frozen in ST_FREEZE
  always_comb begin
    disp_num_d   = disp_num_q;
    disp_src_d   = disp_src_q;
    disp_ovf_d   = disp_ovf_q;
    disp_blank_d = disp_blank_q;
    sel_change_d = 1'b0;
    if (state_q != ST_FREEZE) begin
      disp_src_d   = cur_sel_q;
      sel_change_d = (cur_sel_q != disp_src_q);
      if (!src_valid[cur_sel_q]) begin
        disp_num_d   = '0;
        disp_ovf_d   = 1'b0;
        disp_blank_d = 1'b1;
      end else if (src_val[cur_sel_q] > DW'(MAXVAL)) begin
        disp_num_d   = DW'(MAXVAL);
        disp_ovf_d   = 1'b1;
        disp_blank_d = 1'b0;
      end else begin
        disp_num_d   = src_val[cur_sel_q];
        disp_ovf_d   = 1'b0;
        disp_blank_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ROTATE;
      mode_q       <= MODE_ROTATE;
      frz_evt_q    <= 1'b0;
      cur_sel_q    <= '0;
      dwell_q      <= '0;
      hold_q       <= '0;
      pending_q    <= '0;
      disp_num_q   <= '0;
      disp_src_q   <= '0;
      disp_ovf_q   <= 1'b0;
      disp_blank_q <= 1'b1;
      sel_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      frz_evt_q    <= frz_evt_d;
      cur_sel_q    <= cur_sel_d;
      dwell_q      <= dwell_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      disp_num_q   <= disp_num_d;
      disp_src_q   <= disp_src_d;
      disp_ovf_q   <= disp_ovf_d;
      disp_blank_q <= disp_blank_d;
      sel_change_q <= sel_change_d;
    end
  end

  assign disp_num   = disp_num_q;
  assign disp_src   = disp_src_q;
  assign disp_ovf   = disp_ovf_q;
  assign disp_blank = disp_blank_q;
  assign sel_change = sel_change_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench for display_source_scheduler with NSRC=4, DWELL=8, HOLD=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_display_source_scheduler;

  localparam logic [1:0] M_MAN = 2'b00;
  localparam logic [1:0] M_ROT = 2'b01;
  localparam logic [1:0] M_EVT = 2'b10;
  localparam logic [1:0] M_FRZ = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] src_data;
  logic [3:0]  src_valid;
  logic [3:0]  src_upd;
  logic [1:0]  mode;
  logic [1:0]  man_sel;
  logic [15:0] disp_num;
  logic [1:0]  disp_src;
  logic        disp_ovf;
  logic        disp_blank;
  logic        sel_change;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_source_scheduler #(
    .NSRC(4), .DW(16), .DWELL(8), .HOLD(4), .MAXVAL(9999)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_upd    (src_upd),
    .mode       (mode),
    .man_sel    (man_sel),
    .disp_num   (disp_num),
    .disp_src   (disp_src),
    .disp_ovf   (disp_ovf),
    .disp_blank (disp_blank),
    .sel_change (sel_change)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s value=%0d t=%0t", tag, got, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    src_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    src_valid = 4'b1111;
    src_upd   = 4'b0000;
    mode      = M_ROT;
    man_sel   = 2'd0;
    step(3);
    chk("rst_num",   32'(disp_num),   0);
    chk("rst_src",   32'(disp_src),   0);
    chk("rst_ovf",   32'(disp_ovf),   0);
    chk("rst_blank", 32'(disp_blank), 1);
    chk("rst_chg",   32'(sel_change), 0);
    rst_n = 1'b1;

    // ROTATE, all valid: 1 for 8 cycles then 2,3,4,1 every 8 cycles
    for (int n = 1; n <= 33; n++) begin
      step(1);
      chk($sformatf("rot_num_%0d", n), 32'(disp_num), 32'(((n - 1) / 8) % 4 + 1));
      chk($sformatf("rot_chg_%0d", n), 32'(sel_change),
          32'((n > 1) && ((n - 1) % 8 == 0)));
    end

    // ROTATE with only sources 1 and 3 valid
    src_valid = 4'b1010;
    step(1);
    chk("alt_blank0", 32'(disp_blank), 1);
    chk("alt_num0",   32'(disp_num),   0);
    step(7);
    chk("alt_src1",   32'(disp_src),   1);
    chk("alt_chg1",   32'(sel_change), 1);
    step(8);
    chk("alt_src3",   32'(disp_src),   3);
    step(8);
    chk("alt_src1b",  32'(disp_src),   1);

    // No source valid for 16 cycles
    src_valid = 4'b0000;
    step(16);
    chk("none_blank", 32'(disp_blank), 1);
    chk("none_num",   32'(disp_num),   0);
    chk("none_src",   32'(disp_src),   1);
    chk("none_chg",   32'(sel_change), 0);

    // MANUAL with saturation and boundary values
    src_valid = 4'b1111;
    src_data  = {16'd4, 16'd12345, 16'd2, 16'd1};
    mode      = M_MAN;
    man_sel   = 2'd2;
    step(3);
    chk("man_num_sat", 32'(disp_num), 9999);
    chk("man_ovf_sat", 32'(disp_ovf), 1);
    chk("man_src",     32'(disp_src), 2);
    src_valid = 4'b1011;
    step(1);
    chk("man_blank",   32'(disp_blank), 1);
    chk("man_bl_num",  32'(disp_num),   0);
    chk("man_bl_ovf",  32'(disp_ovf),   0);
    src_valid = 4'b1111;
    src_data  = {16'd4, 16'd9999, 16'd2, 16'd1};
    step(1);
    chk("man_num_max", 32'(disp_num), 9999);
    chk("man_ovf_max", 32'(disp_ovf), 0);
    src_data  = {16'd4, 16'd10000, 16'd2, 16'd1};
    step(1);
    chk("man_num_10k", 32'(disp_num), 9999);
    chk("man_ovf_10k", 32'(disp_ovf), 1);
    src_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    man_sel   = 2'd0;
    step(2);
    chk("man_src0",    32'(disp_src),   0);
    chk("man_chg0",    32'(sel_change), 1);
    chk("man_num0",    32'(disp_num),   1);

    // EVENT: simultaneous updates on 2 and 3
    mode = M_EVT;
    step(1);
    src_upd = 4'b1100;
    step(1);
    src_upd = 4'b0000;
    step(1);
    chk("evt_src2",  32'(disp_src),   2);
    chk("evt_num2",  32'(disp_num),   3);
    chk("evt_chg2",  32'(sel_change), 1);
    step(3);
    chk("evt_src2e", 32'(disp_src),   2);
    step(1);
    chk("evt_src3",  32'(disp_src),   3);
    chk("evt_chg3",  32'(sel_change), 1);
    step(3);
    chk("evt_src3e", 32'(disp_src),   3);
    step(8);
    chk("evt_rot3",  32'(disp_src),   3);
    step(1);
    chk("evt_rot0",  32'(disp_src),   0);

    // EVENT: update on the held source extends its hold
    src_upd = 4'b0100;
    step(1);
    src_upd = 4'b0000;
    step(1);
    chk("ext_src2",  32'(disp_src), 2);
    src_upd = 4'b1100;
    step(1);
    src_upd = 4'b0000;
    step(4);
    chk("ext_src2e", 32'(disp_src), 2);
    step(1);
    chk("ext_src3",  32'(disp_src), 3);

    // FREEZE during hold with changing data and an update on 1
    mode = M_FRZ;
    step(1);
    src_data = {16'd40, 16'd30, 16'd20, 16'd10};
    src_upd  = 4'b0010;
    step(1);
    src_upd  = 4'b0000;
    chk("frz_num",   32'(disp_num),   4);
    chk("frz_src",   32'(disp_src),   3);
    chk("frz_chg",   32'(sel_change), 0);
    step(3);
    chk("frz_num2",  32'(disp_num),   4);
    chk("frz_src2",  32'(disp_src),   3);
    chk("frz_chg2",  32'(sel_change), 0);
    mode = M_EVT;
    step(3);
    chk("unfrz_src", 32'(disp_src),   1);
    chk("unfrz_num", 32'(disp_num),   20);
    chk("unfrz_chg", 32'(sel_change), 1);

    // Reset mid-hold with pending = 4'b0110
    src_upd = 4'b1000;
    step(1);
    src_upd = 4'b0000;
    step(2);
    src_upd = 4'b0110;
    step(1);
    src_upd = 4'b0000;
    chk("pre_rst_src", 32'(disp_src), 3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mrst_blank", 32'(disp_blank), 1);
    chk("mrst_num",   32'(disp_num),   0);
    chk("mrst_src",   32'(disp_src),   0);
    step(3);
    chk("mrst_src_a", 32'(disp_src), 0);
    step(4);
    chk("mrst_src_b", 32'(disp_src), 0);
    step(3);
    chk("mrst_rot1",  32'(disp_src), 1);
    step(7);
    chk("mrst_rot1e", 32'(disp_src), 1);
    step(1);
    chk("mrst_rot2",  32'(disp_src), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
